// File: rtl/dmem_lsu.sv
// RV32 data memory with integrated load/store unit: byte-lane stores, extended loads, fault checks.
// Define DMEM_CLEAR_EN to zero the whole array after every reset with a sequenced clear FSM.
module dmem_lsu #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          IW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic          accept;
  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          legal;
  logic          misal;
  logic          oor;
  logic          req_err;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          clearing;
  logic [IW-1:0] clr_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [IW-1:0] mem_idx;
  logic          rd_en;
  logic [31:0]   rd_word;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  localparam logic [IW-1:0] CLR_LAST = IW'(DEPTH - 1);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] clr_cnt_q;
  logic [IW-1:0] clr_cnt_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clearing  = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing  = 1'b1;
        busy      = 1'b1;
        clr_cnt_d = clr_cnt_q + {{(IW-1){1'b0}}, 1'b1};
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      default: begin
        req_ready = 1'b1;
      end
    endcase
  end

  assign clr_idx = clr_cnt_q;
`else
  assign clearing  = 1'b0;
  assign req_ready = 1'b1;
  assign busy      = 1'b0;
  assign clr_idx   = '0;
`endif

  // Request decode and fault detection
  always_comb begin
    is_b    = (req_funct3[1:0] == 2'b00);
    is_h    = (req_funct3[1:0] == 2'b01);
    is_w    = (req_funct3 == 3'b010);
    legal   = (req_funct3 != 3'b011) && (req_funct3[2:1] != 2'b11);
    misal   = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
    oor     = (req_addr[31:2] >= DEPTH_W);
    req_err = !legal || (req_we && req_funct3[2]) || misal || oor;
  end

  // Contents survive reset when no clear is configured, so no write may land while RESET is high
  assign accept = req_valid && req_ready && !RESET;

  always_comb begin
    st_be   = 4'b1111;
    st_data = req_wdata;
    if (is_b) begin
      st_be   = 4'b0001 << req_addr[1:0];
      st_data = {4{req_wdata[7:0]}};
    end else if (is_h) begin
      st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
      st_data = {2{req_wdata[15:0]}};
    end
  end

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = st_data;
    mem_idx   = req_addr[IW+1:2];
    rd_en     = accept && !req_we && !req_err;
    if (clearing) begin
      mem_be    = 4'b1111;
      mem_wdata = '0;
      mem_idx   = clr_idx;
    end else if (accept && req_we && !req_err) begin
      mem_be = st_be;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_byte_q;

      always_ff @(posedge CLK) begin
        if (mem_be[gi]) begin
          mem[mem_idx] <= mem_wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rd_byte_q <= mem[mem_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_q;
    end
  endgenerate

  // Stage 1: request attributes travel alongside the RAM read
  logic       s1_valid_q;
  logic       s1_valid_d;
  logic       s1_err_q;
  logic       s1_err_d;
  logic       s1_load_q;
  logic       s1_load_d;
  logic [1:0] s1_lane_q;
  logic [1:0] s1_lane_d;
  logic [2:0] s1_f3_q;
  logic [2:0] s1_f3_d;

  always_comb begin
    s1_valid_d = accept;
    s1_err_d   = req_err;
    s1_load_d  = !req_we;
    s1_lane_d  = req_addr[1:0];
    s1_f3_d    = req_funct3;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_load_q  <= 1'b0;
      s1_lane_q  <= 2'b00;
      s1_f3_q    <= 3'b000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_load_q  <= s1_load_d;
      s1_lane_q  <= s1_lane_d;
      s1_f3_q    <= s1_f3_d;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] ld_data;

  always_comb begin
    case (s1_lane_q)
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = s1_lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (s1_f3_q[1:0])
      2'b00:   ld_ext = {{24{ld_byte[7] & ~s1_f3_q[2]}}, ld_byte};
      2'b01:   ld_ext = {{16{ld_half[15] & ~s1_f3_q[2]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
    ld_data = (s1_valid_q && s1_load_q && !s1_err_q) ? ld_ext : 32'h0;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        rsp_valid_q;
      logic        rsp_valid_d;
      logic        rsp_err_q;
      logic        rsp_err_d;
      logic [31:0] rsp_rdata_q;
      logic [31:0] rsp_rdata_d;

      always_comb begin
        rsp_valid_d = s1_valid_q;
        rsp_err_d   = s1_valid_q && s1_err_q;
        rsp_rdata_d = ld_data;
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'h0;
        end else begin
          rsp_valid_q <= rsp_valid_d;
          rsp_err_q   <= rsp_err_d;
          rsp_rdata_q <= rsp_rdata_d;
        end
      end

      assign rsp_valid = rsp_valid_q;
      assign rsp_err   = rsp_err_q;
      assign rsp_rdata = rsp_rdata_q;
    end else begin : g_lat1
      assign rsp_valid = s1_valid_q;
      assign rsp_err   = s1_valid_q && s1_err_q;
      assign rsp_rdata = ld_data;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: two instances (read latency 1 and 2) share one stimulus stream.
// Responses are matched in order against a queue of hand-computed expectations.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, rv1, re1, busy1;
  logic [31:0] rd1;
  logic        rdy2, rv2, re2, busy2;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          k;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

`ifdef DMEM_CLEAR_EN
  localparam logic [31:0] POST_RST_0X10 = 32'h0000_0000;
`else
  localparam logic [31:0] POST_RST_0X10 = 32'h8081_7F01;
`endif

  dmem_lsu #(.DEPTH(16), .READ_LATENCY(1)) u_dut1 (
    .CLK(clk), .RESET(RESET), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .busy(busy1)
  );

  dmem_lsu #(.DEPTH(16), .READ_LATENCY(2)) u_dut2 (
    .CLK(clk), .RESET(RESET), .req_valid(req_valid), .req_ready(rdy2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at the current falling edge; returns at the next falling edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    e.data = ed;
    e.err  = ee;
    e.k    = cyc;
    q1.push_back(e);
    q2.push_back(e);
    $display("txn we=%0d f3=%b addr=%h wdata=%h exp_rdata=%h exp_err=%0d", we, f3, a, wd, ed, ee);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_clear(input string tag);
`ifdef DMEM_CLEAR_EN
    int n;
    n = 0;
    while ((busy1 || busy2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n), 32'd16);
`else
    @(negedge clk);
    chk({tag, "_busy"}, {30'h0, busy1, busy2}, 32'h0);
`endif
    chk({tag, "_ready"}, {30'h0, rdy1, rdy2}, 32'h3);
  endtask

  always @(negedge clk) begin
    if (rv1) begin
      if (q1.size() == 0) begin
        chk("spurious_rsp_lat1", 32'(rv1), 32'h0);
      end else begin
        e1 = q1.pop_front();
        chk("rdata_lat1", rd1, e1.data);
        chk("err_lat1", 32'(re1), 32'(e1.err));
        chk("latency_lat1", 32'(cyc - e1.k), 32'd1);
      end
    end
    if (rv2) begin
      if (q2.size() == 0) begin
        chk("spurious_rsp_lat2", 32'(rv2), 32'h0);
      end else begin
        e2 = q2.pop_front();
        chk("rdata_lat2", rd2, e2.data);
        chk("err_lat2", 32'(re2), 32'(e2.err));
        chk("latency_lat2", 32'(cyc - e2.k), 32'd2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_rsp_valid", {30'h0, rv1, rv2}, 32'h0);
    chk("rst_rdata1", rd1, 32'h0);
    chk("rst_rdata2", rd2, 32'h0);
    chk("rst_err", {30'h0, re1, re2}, 32'h0);
`ifdef DMEM_CLEAR_EN
    chk("rst_busy", {30'h0, busy1, busy2}, 32'h3);
    chk("rst_ready", {30'h0, rdy1, rdy2}, 32'h0);
`else
    chk("rst_busy", {30'h0, busy1, busy2}, 32'h0);
    chk("rst_ready", {30'h0, rdy1, rdy2}, 32'h3);
`endif

`ifdef DMEM_CLEAR_EN
    // Interrupt a clear part way, then let a full one complete
    RESET = 1'b0;
    repeat (5) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
`endif
    RESET = 1'b0;
    wait_clear("clear_cycles");

`ifdef DMEM_CLEAR_EN
    issue(1'b0, 3'b010, 32'h3C, 32'h0, 32'h0, 1'b0);
`endif

    // Store then extended loads, back to back
    issue(1'b1, 3'b010, 32'h10, 32'h8081_7F01, 32'h0, 1'b0);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_0001, 1'b0);
    issue(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FF81, 1'b0);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8081, 1'b0);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8081, 1'b0);
    issue(1'b0, 3'b001, 32'h10, 32'h0, 32'h0000_7F01, 1'b0);

    // Byte-lane merge with read-after-write
    issue(1'b1, 3'b010, 32'h20, 32'hAAAA_AAAA, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h21, 32'h0000_0055, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h22, 32'h0000_1234, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h1234_55AA, 1'b0);

    // Faults: misaligned, out of range, illegal codes; none may disturb memory
    issue(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'b001, 32'h11, 32'h0000_FFFF, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8081_7F01, 1'b0);
    idle(3);

    // Four consecutive loads
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h1234_55AA, 1'b0);
    issue(1'b0, 3'b000, 32'h11, 32'h0, 32'h0000_007F, 1'b0);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8081, 1'b0);
    issue(1'b0, 3'b100, 32'h10, 32'h0, 32'h0000_0001, 1'b0);
    idle(4);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_q2", 32'(q2.size()), 32'd0);

    // Reset right after a load is accepted: its response must never appear
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    $display("txn load 0x10 interrupted by reset, no response expected");
    @(posedge clk);
    #1;
    RESET     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_drop_valid", {30'h0, rv1, rv2}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_drop_valid_late", {30'h0, rv1, rv2}, 32'h0);
    RESET = 1'b0;
    wait_clear("clear_after_rst");
    issue(1'b0, 3'b010, 32'h10, 32'h0, POST_RST_0X10, 1'b0);
    idle(4);
    chk("final_q1", 32'(q1.size()), 32'd0);
    chk("final_q2", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
